sd_accum: RTL and testbench
===========================

// Module: sd_accum
// PURPOSE
//   Synapse/dendrite accumulate stage, directly downstream of the axon slide engine.
//   - Consumes one (vm_addr, wgt_addr) pair per cycle.
//   - Fetches the signed synaptic weight and the target membrane potential.
//   - Adds them with saturation and writes the sum back to the Vm memory.
//   - Fully pipelined with read-after-write forwarding; never stalls the axon.
// PARAMETERS
//   NNW  12  neuron (Vm) address width
//   WD   6   weight address width
//   WW   8   weight data width, two's complement
//   VW   16  membrane potential width, two's complement
// PORTS
//   clk            in   1    single clock, all state on rising edge
//   rst            in   1    asynchronous, active-high reset
//   axon_sd_vld    in   1    address pair valid this cycle
//   axon_sd_vm_addr in  NNW  target neuron address
//   axon_sd_wgt_addr in WD   weight address
//   wgt_raddr      out  WD   weight RAM read address (sync read, 1-cycle latency)
//   wgt_rdata      in   WW   weight RAM read data
//   vm_raddr       out  NNW  Vm RAM read address (sync read, 1-cycle latency, RDW returns OLD data)
//   vm_rdata       in   VW   Vm RAM read data
//   vm_we          out  1    Vm RAM write enable
//   vm_waddr       out  NNW  Vm RAM write address
//   vm_wdata       out  VW   Vm RAM write data
//   sd_idle        out  1    high when no item is in flight (E/W stages empty)
//   sd_sat         out  1    sticky: any accumulation saturated since reset
// BEHAVIOUR
//   - Issue (cycle t):
//     - wgt_raddr = axon_sd_wgt_addr; vm_raddr = axon_sd_vm_addr (combinational pass-through).
//     - Registers valid and vm_addr into stage E.
//   - E (t+1):
//     - w = sign-extend(wgt_rdata) to VW.
//     - Vm operand = forwarded value (see below) else vm_rdata.
//     - sum = operand + w, computed at VW+1 bits.
//     - Saturation: sum > 2^(VW-1)-1 -> max; sum < -2^(VW-1) -> min; sd_sat set.
//   - W (t+2): vm_we = 1, vm_waddr = E addr, vm_wdata = saturated sum, all registered.
//   - Latency: vld at t -> write at t+2. Throughput: 1 per cycle, no backpressure.
//   - Forwarding, checked in E with priority W over W2:
//     - W: item writing this cycle, same addr -> use its vm_wdata.
//     - W2: item that wrote last cycle (registered copy), same addr -> use its data.
//     - Otherwise use vm_rdata.
//   - Result: back-to-back or gap-1 hits on one neuron accumulate exactly, as if serialised.
//   - No state machine beyond the valid pipeline: E_vld <- axon_sd_vld, W_vld <- E_vld, W2_vld <- W_vld.
//   - sd_idle = !E_vld && !W_vld. W2 does not hold idle; its write is already complete.
//   - Reset values: vm_we=0, vm_waddr=0, vm_wdata=0, sd_idle=1, sd_sat=0, all valids=0.
//   - Reset mid-operation: in-flight items are dropped, and vm_we deasserts asynchronously with rst.
//   - Addresses pass unchecked; wrap is the memory's concern. Weight 0 still performs the write.
//   - X on addresses while axon_sd_vld=0 must not affect state.
// TESTING
//   - Single: Vm[5]=100, W[3]=-20, one vld(5,3)
//     -> vm_we exactly at t+2, addr 5, data 80; sd_idle low t+1..t+2.
//   - Back-to-back hazard: Vm[7]=0, W[1]=10, 4 consecutive vld(7,1)
//     -> writes 10, 20, 30, 40 on four consecutive cycles.
//   - Gap-1 hazard: vld(9,1), idle, vld(9,1) with W[1]=5, Vm[9]=0
//     -> second write = 10 (W2 path).
//   - Interleave: vld(2,a), vld(4,b), vld(2,a) with W[a]=1, W[b]=2, Vm=0
//     -> writes 1 @2, 2 @4, 2 @2.
//   - Saturation: Vm[0]=32760, W=+100 -> writes 32767, sd_sat=1.
//     Vm[1]=-32760, W=-100 -> writes -32768.
//   - Reset: assert rst while 3 items are in flight
//     -> vm_we=0 immediately, no writes after release, sd_idle=1, sd_sat=0.

Source files
------------

// File: rtl/sd_accum.sv
// Synapse/dendrite accumulate stage: Vm[addr] += sext(W[waddr]) with saturation,
// fully pipelined (issue -> E -> W) with W/W2 read-after-write forwarding.
module sd_accum #(
  parameter int NNW = 12,
  parameter int WD  = 6,
  parameter int WW  = 8,
  parameter int VW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           axon_sd_vld,
  input  logic [NNW-1:0] axon_sd_vm_addr,
  input  logic [WD-1:0]  axon_sd_wgt_addr,
  output logic [WD-1:0]  wgt_raddr,
  input  logic [WW-1:0]  wgt_rdata,
  output logic [NNW-1:0] vm_raddr,
  input  logic [VW-1:0]  vm_rdata,
  output logic           vm_we,
  output logic [NNW-1:0] vm_waddr,
  output logic [VW-1:0]  vm_wdata,
  output logic           sd_idle,
  output logic           sd_sat
);
  localparam int STAGES = 3;  // E, W, W2

  logic [STAGES:1] vld_pipe;
  logic [NNW-1:0]  e_addr, w2_addr;
  logic [VW-1:0]   w2_data, w_ext, op, sat_val;
  logic [VW:0]     sum;
  logic            ovf;

  assign wgt_raddr = axon_sd_wgt_addr;
  assign vm_raddr  = axon_sd_vm_addr;
  assign vm_we     = vld_pipe[2];
  assign sd_idle   = !vld_pipe[1] && !vld_pipe[2];

  assign w_ext = {{(VW-WW){wgt_rdata[WW-1]}}, wgt_rdata};

  // W overrides W2: it is the younger write to the same neuron.
  always_comb begin
    op = vm_rdata;
    if (vld_pipe[3] && w2_addr == e_addr)   op = w2_data;
    if (vld_pipe[2] && vm_waddr == e_addr)  op = vm_wdata;
  end

  assign sum = {op[VW-1], op} + {w_ext[VW-1], w_ext};
  assign ovf = sum[VW] ^ sum[VW-1];

  always_comb begin
    sat_val = sum[VW-1:0];
    if (ovf) sat_val = sum[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], axon_sd_vld};
  end

  // Data registers only load behind a valid bit so idle-cycle X addresses never leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_addr   <= '0;
      vm_waddr <= '0;
      vm_wdata <= '0;
      w2_addr  <= '0;
      w2_data  <= '0;
      sd_sat   <= 1'b0;
    end else begin
      if (axon_sd_vld) e_addr <= axon_sd_vm_addr;
      if (vld_pipe[1]) begin
        vm_waddr <= e_addr;
        vm_wdata <= sat_val;
        if (ovf) sd_sat <= 1'b1;
      end
      if (vld_pipe[2]) begin
        w2_addr <= vm_waddr;
        w2_data <= vm_wdata;
      end
    end
  end
endmodule

// File: tb/tb_sd_accum.sv
// Bench for sd_accum: RAM models, serial reference model feeding a scoreboard queue,
// and an independent monitor that checks every Vm write, its timing, and sd_idle.
module tb_sd_accum;
  localparam int NNW = 12, WD = 6, WW = 8, VW = 16;

  logic           clk = 0, rst = 1;
  logic           axon_sd_vld = 0;
  logic [NNW-1:0] axon_sd_vm_addr = '0;
  logic [WD-1:0]  axon_sd_wgt_addr = '0;
  logic [WD-1:0]  wgt_raddr;
  logic [WW-1:0]  wgt_rdata;
  logic [NNW-1:0] vm_raddr;
  logic [VW-1:0]  vm_rdata;
  logic           vm_we;
  logic [NNW-1:0] vm_waddr;
  logic [VW-1:0]  vm_wdata;
  logic           sd_idle, sd_sat;

  sd_accum #(.NNW(NNW), .WD(WD), .WW(WW), .VW(VW)) dut (
    .clk(clk), .rst(rst), .axon_sd_vld(axon_sd_vld),
    .axon_sd_vm_addr(axon_sd_vm_addr), .axon_sd_wgt_addr(axon_sd_wgt_addr),
    .wgt_raddr(wgt_raddr), .wgt_rdata(wgt_rdata),
    .vm_raddr(vm_raddr), .vm_rdata(vm_rdata),
    .vm_we(vm_we), .vm_waddr(vm_waddr), .vm_wdata(vm_wdata),
    .sd_idle(sd_idle), .sd_sat(sd_sat));

  always #5 clk = ~clk;

  // Synchronous RAMs, read-during-write returns old data.
  logic [WW-1:0]  wmem [1<<WD];
  logic [VW-1:0]  vmem [1<<NNW];
  logic           init_en = 0;
  logic [NNW-1:0] init_a = '0;
  logic [VW-1:0]  init_d = '0;
  always @(posedge clk) begin
    wgt_rdata <= wmem[wgt_raddr];
    vm_rdata  <= vmem[vm_raddr];
    if (vm_we)   vmem[vm_waddr] <= vm_wdata;
    if (init_en) vmem[init_a]   <= init_d;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } exp_t;
  exp_t exp_q[$];
  int   ref_vm [int];
  bit   issued [int];
  bit   sat_ref = 0;
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every observed write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (vm_we) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_write: addr %0d data %0d with empty queue", vm_waddr, $signed(vm_wdata));
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", vm_waddr, e.addr);
            chk("wr_data", $signed(vm_wdata), e.data);
            chk("wr_cycle", cyc, e.cyc);
          end
        end
        chk("sd_idle", sd_idle, !(issued.exists(cyc-1) || issued.exists(cyc-2)));
      end
    end
  end

  task automatic init_vm(input int a, input int d);
    @(negedge clk);
    init_en = 1; init_a = NNW'(a); init_d = VW'(d);
    ref_vm[a] = int'($signed(VW'(d)));
    @(posedge clk); #1 init_en = 0;
  endtask

  // Reference: each item is applied serially to the neuron array at issue time.
  task automatic issue(input bit v, input int va, input int wa);
    int s;
    @(negedge clk);
    axon_sd_vld = v;
    if (v) begin
      axon_sd_vm_addr  = NNW'(va);
      axon_sd_wgt_addr = WD'(wa);
      s = ref_vm[va] + int'($signed(wmem[wa]));
      if (s > 32767)  begin s = 32767;  sat_ref = 1; end
      if (s < -32768) begin s = -32768; sat_ref = 1; end
      ref_vm[va] = s;
      exp_q.push_back('{va, s, cyc + 2});
      issued[cyc] = 1;
    end else begin
      axon_sd_vm_addr  = 'x;
      axon_sd_wgt_addr = 'x;
    end
  endtask

  task automatic drain();
    repeat (4) issue(0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("sd_sat", sd_sat, sat_ref);
  endtask

  initial begin
    for (int i = 0; i < (1<<WD); i++) wmem[i] = WW'($urandom);
    #2;
    chk("rst_vm_we", vm_we, 0);
    chk("rst_vm_waddr", vm_waddr, 0);
    chk("rst_vm_wdata", vm_wdata, 0);
    chk("rst_sd_idle", sd_idle, 1);
    chk("rst_sd_sat", sd_sat, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 16; i++) init_vm(i, 0);

    // single
    init_vm(5, 100); wmem[3] = WW'(-20);
    issue(1, 5, 3); drain();
    // back-to-back
    wmem[1] = 8'd10;
    repeat (4) issue(1, 7, 1);
    drain();
    // gap-1
    wmem[1] = 8'd5;
    issue(1, 9, 1); issue(0, 0, 0); issue(1, 9, 1); drain();
    // interleave
    wmem[12] = 8'd1; wmem[13] = 8'd2;
    issue(1, 2, 12); issue(1, 4, 13); issue(1, 2, 12); drain();
    // saturation, both rails
    init_vm(0, 32760); init_vm(1, -32760);
    wmem[20] = 8'd100; wmem[21] = WW'(-100);
    issue(1, 0, 20); issue(1, 1, 21); drain();

    // reset with three items in flight
    issue(1, 5, 3); issue(1, 7, 1); issue(1, 9, 1);
    @(posedge clk); #2 rst = 1;
    #1;
    axon_sd_vld = 0;
    chk("midrst_vm_we", vm_we, 0);
    chk("midrst_sd_idle", sd_idle, 1);
    chk("midrst_sd_sat", sd_sat, 0);
    exp_q.delete(); issued.delete(); sat_ref = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (5) issue(0, 0, 0);
    chk("post_rst_sd_sat", sd_sat, 0);
    chk("post_rst_queue", exp_q.size(), 0);

    // random traffic on a few neurons to exercise both forwarding paths
    wmem[0] = '0;
    for (int i = 0; i < 8; i++)
      init_vm(i, ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) != 0) ? 32700 : -32700)
                                             : int'($signed(16'($urandom))));
    for (int i = 0; i < 500; i++)
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, (1<<WD)-1));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
